// File: rtl/masked_round_state_reg.sv
// masked_round_state_reg
//   Share-aware round-state register with round sequencing for a masked
//   (threshold-implementation) Midori64 datapath. Selects between the initial
//   plaintext shares and the round-function output shares, holds the state
//   while a STAGES-deep round function settles, counts ROUNDS rounds and
//   pulses done once the final round has been captured.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      begin an encryption (sampled in IDLE only)
//   abort      synchronous flush to IDLE, clears all shares
//   load_in    initial state shares   (WIDTH*SHARES)
//   round_in   round-function shares  (WIDTH*SHARES)
//   state_out  registered state shares feeding the round function
//   round_idx  index of the round currently being computed
//   last_round high in RUN while round_idx == ROUNDS-1
//   busy       high in RUN
//   done       one-cycle pulse, state_out holds the result meanwhile
module masked_round_state_reg #(
    parameter int WIDTH  = 64,
    parameter int SHARES = 3,
    parameter int ROUNDS = 16,
    parameter int STAGES = 1,
    localparam int RW    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [WIDTH*SHARES-1:0]   load_in,
    input  logic [WIDTH*SHARES-1:0]   round_in,
    output logic [WIDTH*SHARES-1:0]   state_out,
    output logic [RW-1:0]             round_idx,
    output logic                      last_round,
    output logic                      busy,
    output logic                      done
);

    localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [SW-1:0] STG_LAST = SW'(STAGES - 1);
    localparam logic [RW-1:0] IDX_LAST = RW'(ROUNDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]              r_state;
    logic [SW-1:0]           r_stg;
    logic [RW-1:0]           r_idx;
    logic [WIDTH*SHARES-1:0] r_state_out;

    logic                    w_load;
    logic                    w_capture;
    logic [WIDTH*SHARES-1:0] w_state_next;

    assign w_load    = (r_state == S_IDLE) && start;
    assign w_capture = (r_state == S_RUN) && (r_stg == STG_LAST);

    // Each share slice gets its own mux driven by the common select, so no
    // logic ever sees bits of two different shares together.
    for (genvar gi = 0; gi < SHARES; gi++) begin : g_share
        assign w_state_next[gi*WIDTH +: WIDTH] =
            abort     ? '0 :
            w_load    ? load_in[gi*WIDTH +: WIDTH] :
            w_capture ? round_in[gi*WIDTH +: WIDTH] :
                        r_state_out[gi*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_out <= '0;
        end else begin
            r_state_out <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_stg   <= '0;
            r_idx   <= '0;
        end else if (abort) begin
            r_state <= S_IDLE;
            r_stg   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_stg   <= '0;
                        r_idx   <= '0;
                    end
                end
                S_RUN: begin
                    if (r_stg != STG_LAST) begin
                        r_stg <= r_stg + SW'(1);
                    end else begin
                        r_stg <= '0;
                        if (r_idx != IDX_LAST) begin
                            r_idx <= r_idx + RW'(1);
                        end else begin
                            r_idx   <= '0;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_stg   <= '0;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    assign state_out  = r_state_out;
    assign round_idx  = r_idx;
    assign busy       = (r_state == S_RUN);
    assign done       = (r_state == S_DONE);
    assign last_round = busy && (r_idx == IDX_LAST);

endmodule

// File: tb/tb_masked_round_state_reg.sv
module tb_masked_round_state_reg;

    localparam int W  = 64;
    localparam int SH = 3;
    localparam int BW = W * SH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          abort;
    logic          start_a;
    logic          start_b;
    logic [BW-1:0] load_in;
    logic [BW-1:0] round_in;

    logic [BW-1:0] state_a;
    logic [3:0]    idx_a;
    logic          last_a, busy_a, done_a;
    logic [BW-1:0] state_b;
    logic [1:0]    idx_b;
    logic          last_b, busy_b, done_b;

    int checks_pass  = 0;
    int checks_total = 0;

    // Default configuration: 16 rounds, one cycle per round
    masked_round_state_reg #(.WIDTH(W), .SHARES(SH), .ROUNDS(16), .STAGES(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort),
        .load_in(load_in), .round_in(round_in), .state_out(state_a),
        .round_idx(idx_a), .last_round(last_a), .busy(busy_a), .done(done_a)
    );

    // Multi-stage round function: 4 rounds, three cycles each
    masked_round_state_reg #(.WIDTH(W), .SHARES(SH), .ROUNDS(4), .STAGES(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort),
        .load_in(load_in), .round_in(round_in), .state_out(state_b),
        .round_idx(idx_b), .last_round(last_b), .busy(busy_b), .done(done_b)
    );

    function automatic logic [BW-1:0] rand_bus();
        logic [BW-1:0] v;
        for (int i = 0; i < BW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reset is asynchronous: outputs must clear before any clock edge, and
    // stay quiet through idle cycles with toggling data inputs.
    task automatic test_reset();
        rst = 1'b1; abort = 1'b0; start_a = 1'b0; start_b = 1'b0;
        load_in = rand_bus(); round_in = rand_bus();
        #3;
        checks_total++;
        if ({state_a, idx_a, last_a, busy_a, done_a} !== '0) begin
            $display("FAIL reset_async_a got state=%h idx=%0d last=%b busy=%b done=%b exp all 0",
                     state_a, idx_a, last_a, busy_a, done_a);
        end else checks_pass++;
        checks_total++;
        if ({state_b, idx_b, last_b, busy_b, done_b} !== '0) begin
            $display("FAIL reset_async_b got state=%h busy=%b done=%b exp all 0", state_b, busy_b, done_b);
        end else checks_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            load_in = rand_bus(); round_in = rand_bus();
            @(posedge clk); #1;
            checks_total++;
            if ({state_a, busy_a, done_a, state_b, busy_b, done_b} !== '0) begin
                $display("FAIL reset_idle c=%0d got a=%h/%b/%b b=%h/%b/%b exp 0",
                         c, state_a, busy_a, done_a, state_b, busy_b, done_b);
            end else checks_pass++;
        end
    endtask

    // Full encryption on one DUT, checked every cycle against the timing
    // rules: load at t+1, captures at t+1+r*S, done at t+1+R*S, idle after.
    // With noise, start is toggled randomly during RUN and DONE.
    task automatic test_run(input bit use_a, input bit noise);
        int            r_cnt;
        int            s_cnt;
        int            last_k;
        int            exp_idx;
        bit            exp_busy, exp_done, exp_last;
        logic [BW-1:0] exp_state, load_val, rin_edge;
        logic [BW-1:0] o_state;
        logic [3:0]    o_idx;
        logic          o_last, o_busy, o_done;
        r_cnt  = use_a ? 16 : 4;
        s_cnt  = use_a ? 1 : 3;
        last_k = r_cnt * s_cnt + 2;
        load_val = rand_bus();
        load_in  = load_val;
        round_in = rand_bus();
        if (use_a) start_a = 1'b1; else start_b = 1'b1;
        exp_state = '0;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        rin_edge = '0;
        for (int k = 1; k <= last_k; k++) begin
            if (k == 1) exp_state = load_val;
            else if (k <= r_cnt * s_cnt + 1 && (k - 1) % s_cnt == 0) exp_state = rin_edge;
            exp_busy = (k <= r_cnt * s_cnt);
            exp_done = (k == r_cnt * s_cnt + 1);
            exp_idx  = exp_busy ? (k - 1) / s_cnt : 0;
            exp_last = exp_busy && (exp_idx == r_cnt - 1);
            o_state = use_a ? state_a : state_b;
            o_idx   = use_a ? idx_a : {2'b00, idx_b};
            o_last  = use_a ? last_a : last_b;
            o_busy  = use_a ? busy_a : busy_b;
            o_done  = use_a ? done_a : done_b;
            checks_total++;
            if (o_state !== exp_state) begin
                $display("FAIL run_state dut=%s k=%0d got %h exp %h", use_a ? "a" : "b", k, o_state, exp_state);
            end else checks_pass++;
            checks_total++;
            if (o_idx !== 4'(exp_idx)) begin
                $display("FAIL run_idx dut=%s k=%0d got %0d exp %0d", use_a ? "a" : "b", k, o_idx, exp_idx);
            end else checks_pass++;
            checks_total++;
            if (o_last !== exp_last) begin
                $display("FAIL run_last dut=%s k=%0d got %b exp %b", use_a ? "a" : "b", k, o_last, exp_last);
            end else checks_pass++;
            checks_total++;
            if (o_busy !== exp_busy) begin
                $display("FAIL run_busy dut=%s k=%0d got %b exp %b", use_a ? "a" : "b", k, o_busy, exp_busy);
            end else checks_pass++;
            checks_total++;
            if (o_done !== exp_done) begin
                $display("FAIL run_done dut=%s k=%0d got %b exp %b", use_a ? "a" : "b", k, o_done, exp_done);
            end else checks_pass++;
            round_in = rand_bus();
            rin_edge = round_in;
            load_in  = rand_bus();
            if (noise && k <= r_cnt * s_cnt + 1) begin
                if (use_a) start_a = 1'($urandom_range(0, 1));
                else       start_b = 1'($urandom_range(0, 1));
            end else begin
                start_a = 1'b0; start_b = 1'b0;
            end
            if (k < last_k) begin
                @(posedge clk); #1;
            end
        end
        start_a = 1'b0; start_b = 1'b0;
    endtask

    // Abort after k_abort edges of a run, optionally with start raised in
    // the same cycle; everything clears and no done pulse follows.
    task automatic test_abort(input bit use_a, input int k_abort, input bit with_start);
        int seen_done;
        load_in = rand_bus();
        if (use_a) start_a = 1'b1; else start_b = 1'b1;
        for (int k = 0; k < k_abort; k++) begin
            @(posedge clk); #1;
            start_a = 1'b0; start_b = 1'b0;
            round_in = rand_bus();
        end
        abort = 1'b1;
        if (with_start) begin
            if (use_a) start_a = 1'b1; else start_b = 1'b1;
        end
        @(posedge clk); #1;
        abort = 1'b0; start_a = 1'b0; start_b = 1'b0;
        checks_total++;
        if ((use_a ? state_a : state_b) !== '0) begin
            $display("FAIL abort_state dut=%s got %h exp 0", use_a ? "a" : "b", use_a ? state_a : state_b);
        end else checks_pass++;
        checks_total++;
        if ((use_a ? {idx_a, last_a, busy_a, done_a} : {2'b00, idx_b, last_b, busy_b, done_b}) !== 7'd0) begin
            $display("FAIL abort_ctrl dut=%s got idx=%0d last=%b busy=%b done=%b exp 0/0/0/0",
                     use_a ? "a" : "b", use_a ? idx_a : {2'b00, idx_b},
                     use_a ? last_a : last_b, use_a ? busy_a : busy_b, use_a ? done_a : done_b);
        end else checks_pass++;
        seen_done = 0;
        for (int c = 0; c < 20; c++) begin
            round_in = rand_bus(); load_in = rand_bus();
            @(posedge clk); #1;
            if (done_a || done_b || busy_a || busy_b) seen_done++;
        end
        checks_total++;
        if (seen_done !== 0) begin
            $display("FAIL abort_quiet dut=%s got %0d busy/done cycles exp 0", use_a ? "a" : "b", seen_done);
        end else checks_pass++;
    endtask

    // Asynchronous reset between clock edges mid-run, then a fresh run.
    task automatic test_async_reset();
        load_in = rand_bus();
        start_a = 1'b1; start_b = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            start_a = 1'b0; start_b = 1'b0;
            round_in = rand_bus();
        end
        #3;
        rst = 1'b1;
        #1;
        checks_total++;
        if ({state_a, idx_a, last_a, busy_a, done_a} !== '0) begin
            $display("FAIL async_rst_a got state=%h idx=%0d busy=%b done=%b exp all 0",
                     state_a, idx_a, busy_a, done_a);
        end else checks_pass++;
        checks_total++;
        if ({state_b, idx_b, last_b, busy_b, done_b} !== '0) begin
            $display("FAIL async_rst_b got state=%h idx=%0d busy=%b done=%b exp all 0",
                     state_b, idx_b, busy_b, done_b);
        end else checks_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        test_run(1'b1, 1'b0);
        test_run(1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        test_run(1'b1, 1'b1);
        test_run(1'b1, 1'b1);
        test_run(1'b0, 1'b1);
        test_run(1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_run(1'b1, 1'b0);
        test_run(1'b0, 1'b0);
        test_back_to_back();
        test_abort(1'b1, 6, 1'b1);
        test_abort(1'b1, 6, 1'b0);
        test_abort(1'b0, 5, 1'b1);
        test_run(1'b0, 1'b0);
        test_async_reset();
        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

endmodule

// File: doc/masked_round_state_reg.md
# masked_round_state_reg

Parametrised, share-aware round-state register with built-in round sequencing for the masked Midori64 datapath. It selects between the initial (plaintext) shares and the round-function output shares, holds the state while a multi-stage TI round function settles, and counts rounds. It asserts `done` when the last round has been captured. It sits between the input share generator and the pipelined TI round function, and generalises the fixed 64-bit two-input select register to any width, share count, round count and round-function latency.

## Interface
- `WIDTH`, 64: bits per share.
- `SHARES`, 3: number of Boolean shares; all share buses are `WIDTH*SHARES` bits, share i at bits `[i*WIDTH +: WIDTH]`.
- `ROUNDS`, 16: number of round-function applications per encryption; must be ≥1.
- `STAGES`, 1: round-function latency in clock cycles (register stages inside the TI round); must be ≥1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin an encryption; sampled only in IDLE.
- `abort`  in  1  synchronous flush; returns to IDLE and clears the state.
- `load_in`  in  WIDTH*SHARES  initial state shares.
- `round_in`  in  WIDTH*SHARES  round-function output shares.
- `state_out`  out  WIDTH*SHARES  registered state shares, which feed the round function.
- `round_idx`  out  RW = max(1, clog2(ROUNDS))  index of the round currently being computed.
- `last_round`  out  1  high in RUN when `round_idx == ROUNDS-1`; this is combinational from registers.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse; `state_out` holds the final result while it is high.

## Operation
- The FSM has three states: IDLE, RUN and DONE. There is also an internal stage counter `stg`, 0..STAGES-1.
- Reset drives the FSM to IDLE. Reset also drives `state_out`, `round_idx`, `stg`, `busy` and `done` to 0.
- IDLE:
  - `state_out` holds its value.
  - `start=1` (with `abort=0`) captures `load_in` into `state_out`, sets `round_idx=0` and `stg=0`, and moves to RUN.
- RUN:
  - When `stg < STAGES-1`: increment `stg`; `state_out` holds.
  - When `stg == STAGES-1`: capture `round_in` into `state_out` and clear `stg` to 0.
    - If `round_idx < ROUNDS-1`, increment `round_idx` and stay in RUN.
    - Otherwise, clear `round_idx` to 0 and go to DONE.
- DONE:
  - `done=1` and `state_out` holds.
  - The FSM moves to IDLE unconditionally on the next edge.
  - `start` is ignored in DONE.
- `start` is ignored in RUN and DONE. There is no queuing.
- `abort=1` in any state, on the next edge:
  - `state_out` is cleared to 0 on all shares, so no share remnant is left.
  - `round_idx` and `stg` are cleared to 0.
  - The FSM moves to IDLE.
- `abort` has priority over `start` and over round capture.
- Shares are never combined. Each share slice is muxed independently with the same select, so no cross-share logic exists in the datapath.

## Timing
- Let `start` be sampled at edge t.
  - `state_out = load_in` and `busy=1` from edge t+1.
  - Round r (1..ROUNDS) is captured at edge t+1+r*STAGES.
  - `busy` falls and `done` rises at edge t+1+ROUNDS*STAGES.
  - `done` falls at edge t+2+ROUNDS*STAGES.
- Start-to-done latency is 1+ROUNDS*STAGES cycles. With defaults this is 17 cycles.
- `round_idx` changes on capture edges only. It is stable for STAGES cycles, so round constants and round keys indexed by it are valid during the whole round.
- A new `start` is accepted at the earliest in the first IDLE cycle after `done`. Back-to-back throughput is 2+ROUNDS*STAGES cycles.
- Asynchronous `rst` mid-run takes effect immediately, without waiting for a clock edge. All outputs are 0 while `rst` is high. The first `start` is accepted at the first edge after deassertion.
- Boundary cases:
  - With `ROUNDS=1`, the machine enters DONE after a single capture. `last_round=1` for the whole RUN.
  - With `STAGES=1`, a capture happens every RUN cycle.

## Test plan
- Reset then idle: assert `rst` mid-cycle → all outputs 0 immediately; 10 idle cycles with toggling `load_in`/`round_in` → `state_out` stays 0 and `busy`/`done` stay 0.
- Defaults (WIDTH=64, SHARES=3, ROUNDS=16, STAGES=1), `load_in`=0x0123…, `round_in` = counter pattern → `state_out=load_in` at t+1; `round_idx` steps 0..15; `last_round` high only at idx 15; `done` pulses exactly at t+17; `state_out` equals `round_in` sampled at edge t+17.
- STAGES=3, ROUNDS=4 → captures at t+4, t+7, t+10 and t+13; `state_out` holds between captures even though `round_in` changes every cycle; `done` at t+13.
- `start` pulses during RUN and during DONE → ignored, latency unchanged; `start` in the first IDLE cycle after `done` → accepted.
- `abort` at round 5, including with simultaneous `start` → next edge: `state_out`=0 on all shares, `round_idx`=0, IDLE, no `done` pulse.
- Asynchronous `rst` asserted mid-round between clock edges → outputs cleared without a clock edge; a fresh run after release completes with correct 17-cycle latency.
